vga_pixel_out: RTL

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

---
 rtl/vga_pixel_out.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_out
// Purpose  : VGA timing generator that streams RGB565 pixels from a show-ahead
//            FIFO. Outputs are registered and a FIFO underflow shows as black.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iENABLE,
  input  logic [15:0] iFIFO_DATA,
  input  logic        iFIFO_EMPTY,
  output logic        oFIFO_RD_EN,
  output logic        oVGA_HSYNC,
  output logic        oVGA_VSYNC,
  output logic [4:0]  oVGA_R,
  output logic [5:0]  oVGA_G,
  output logic [4:0]  oVGA_B,
  output logic        oVGA_BLANK_N,
  output logic        oFRAME_START,
  output logic        oUNDERFLOW,
  output logic [7:0]  oUNDERFLOW_COUNT
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync-end bound never truncates.
  localparam int c_HW = $clog2(c_H_TOTAL + 1);
  localparam int c_VW = $clog2(c_V_TOTAL + 1);

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_HW-1:0]   r_h;
  logic [c_VW-1:0]   r_v;
  logic [c_HW-1:0]   w_h_nxt;
  logic [c_VW-1:0]   w_v_nxt;

  logic              r_hsync;
  logic              r_vsync;
  logic [4:0]        r_red;
  logic [5:0]        r_green;
  logic [4:0]        r_blue;
  logic              r_blank_n;
  logic              r_frame_start;
  logic              r_underflow;
  logic [7:0]        r_uf_count;

  logic w_scan;
  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_pix_ok;
  logic w_underrun;
  logic w_hsync_n;
  logic w_vsync_n;

  assign w_scan     = (r_state != S_IDLE);
  assign w_h_last   = (r_h == c_H_LAST);
  assign w_v_last   = (r_v == c_V_LAST);
  assign w_active   = w_scan && (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_pix_ok   = w_active && !iFIFO_EMPTY;
  assign w_underrun = w_active && iFIFO_EMPTY;
  assign w_hsync_n  = !(w_scan && (r_h >= c_HS_START) && (r_h < c_HS_END));
  assign w_vsync_n  = !(w_scan && (r_v >= c_VS_START) && (r_v < c_VS_END));

  assign oFIFO_RD_EN = w_pix_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = '0;
    w_v_nxt     = '0;
    case (r_state)
      S_IDLE: if (iENABLE) w_state_nxt = S_RUN;
      S_RUN:  if (!iENABLE) w_state_nxt = S_STOP;
      S_STOP: begin
        if (iENABLE)                   w_state_nxt = S_RUN;
        else if (w_h_last && w_v_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Counters stay parked at the origin while idle; otherwise raster scan.
    if (w_scan) begin
      w_h_nxt = w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v + 1'b1;
      else          w_v_nxt = r_v;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else if (iRESET_SYNC) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
      r_uf_count    <= '0;
    end else if (iRESET_SYNC) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
      r_uf_count    <= '0;
    end else begin
      r_hsync       <= w_hsync_n;
      r_vsync       <= w_vsync_n;
      r_red         <= w_pix_ok ? iFIFO_DATA[15:11] : 5'd0;
      r_green       <= w_pix_ok ? iFIFO_DATA[10:5]  : 6'd0;
      r_blue        <= w_pix_ok ? iFIFO_DATA[4:0]   : 5'd0;
      r_blank_n     <= w_active;
      r_frame_start <= (r_state == S_RUN) && (r_h == '0) && (r_v == '0);
      if (w_underrun) begin
        r_underflow <= 1'b1;
        if (r_uf_count != 8'hFF) r_uf_count <= r_uf_count + 8'd1;
      end
    end
  end

  assign oVGA_HSYNC       = r_hsync;
  assign oVGA_VSYNC       = r_vsync;
  assign oVGA_R           = r_red;
  assign oVGA_G           = r_green;
  assign oVGA_B           = r_blue;
  assign oVGA_BLANK_N     = r_blank_n;
  assign oFRAME_START     = r_frame_start;
  assign oUNDERFLOW       = r_underflow;
  assign oUNDERFLOW_COUNT = r_uf_count;

endmodule
`default_nettype wire
